// File: rtl/freq_band_selector.sv
// Frequency band classifier with edge hysteresis, N-of-N confirmation and loss-of-signal timeout.
// Optional statistics outputs (n_changes, n_dropped) are enabled by defining FREQ_BAND_SELECTOR_STATS_EN.
module freq_band_selector #(
  parameter int F_WIDTH        = 14,
  parameter int N_BANDS        = 8,
  parameter int F_MIN          = 500,
  parameter int BAND_STEP      = 250,
  parameter int HYST           = 10,
  parameter int N_CONFIRM      = 3,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [F_WIDTH-1:0]         f,
  input  logic                       f_valid,
  output logic [N_BANDS-1:0]         cap_sel,
  output logic [$clog2(N_BANDS)-1:0] band,
  output logic                       locked,
  output logic                       band_change,
  output logic                       sig_lost,
`ifdef FREQ_BAND_SELECTOR_STATS_EN
  output logic                       busy,
  output logic [7:0]                 n_changes,
  output logic [7:0]                 n_dropped
`else
  output logic                       busy
`endif
);

  localparam int BW = $clog2(N_BANDS);
  localparam int CW = $clog2(N_CONFIRM + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [F_WIDTH-1:0] F_MIN_V  = F_WIDTH'(F_MIN);
  localparam logic [F_WIDTH-1:0] STEP_V   = F_WIDTH'(BAND_STEP);
  localparam logic [F_WIDTH-1:0] HYST_V   = F_WIDTH'(HYST);
  localparam logic [F_WIDTH-1:0] UPPER_V  = F_WIDTH'(BAND_STEP - HYST);
  localparam logic [BW-1:0]      K_MAX    = BW'(N_BANDS - 1);
  localparam logic [CW-1:0]      CONF_V   = CW'(N_CONFIRM);
  localparam logic [TW-1:0]      TMAX     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, CALC, DECIDE} state_t;

  state_t             state, state_nxt;
  logic [F_WIDTH-1:0] r;
  logic [BW-1:0]      k;
  logic               none_f;
  logic               step;
  logic [BW-1:0]      res_k;
  logic               cand_none;
  logic [BW-1:0]      cand_k;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               same, hit;
  logic [TW-1:0]      tcnt;

  assign busy = (state != IDLE);
  assign step = (r >= STEP_V) && (k < K_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_valid) state_nxt = (f < F_MIN_V) ? DECIDE : CALC;
      CALC:    if (!step) state_nxt = DECIDE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Repeated-subtraction classifier: one band step per cycle, top band absorbs overflow
  always_ff @(posedge clk) begin
    if (state == IDLE && f_valid) begin
      none_f <= (f < F_MIN_V);
      r      <= f - F_MIN_V;
      k      <= '0;
    end else if (state == CALC && step) begin
      r <= r - STEP_V;
      k <= k + 1'b1;
    end
  end

  // Hysteresis pulls a result just across a neighbouring edge back to the locked band
  always_comb begin
    res_k = k;
    if (locked && !none_f) begin
      if (({1'b0, k} == ({1'b0, band} + 1'b1)) && (r < HYST_V))
        res_k = band;
      else if ((band != '0) && (k == band - 1'b1) && (r >= UPPER_V))
        res_k = band;
    end
  end

  always_comb begin
    same    = (cand_none == none_f) && (none_f || (cand_k == res_k));
    cnt_nxt = CW'(1);
    if (same) cnt_nxt = (cnt == CONF_V) ? cnt : cnt + 1'b1;
    hit     = (cnt_nxt == CONF_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_sel     <= '0;
      band        <= '0;
      locked      <= 1'b0;
      band_change <= 1'b0;
      sig_lost    <= 1'b0;
      cnt         <= '0;
      cand_none   <= 1'b1;
      cand_k      <= '0;
      tcnt        <= '0;
    end else begin
      band_change <= 1'b0;
      if (state == DECIDE) begin
        cand_none <= none_f;
        cand_k    <= res_k;
        cnt       <= cnt_nxt;
        if (hit) begin
          if (none_f) begin
            cap_sel <= '0;
            locked  <= 1'b0;
            if (cap_sel != '0) band_change <= 1'b1;
          end else if (!locked || (res_k != band)) begin
            band        <= res_k;
            cap_sel     <= N_BANDS'(1) << res_k;
            locked      <= 1'b1;
            band_change <= 1'b1;
          end
        end
      end
      // Loss of signal drops the lock and forgets confirmation, but keeps the bank engaged
      if (f_valid) begin
        tcnt     <= '0;
        sig_lost <= 1'b0;
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TMAX - 1'b1) begin
          sig_lost  <= 1'b1;
          locked    <= 1'b0;
          cnt       <= '0;
          cand_none <= 1'b1;
        end
      end
    end
  end

`ifdef FREQ_BAND_SELECTOR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_changes <= '0;
      n_dropped <= '0;
    end else begin
      if (band_change && (n_changes != 8'hFF)) n_changes <= n_changes + 1'b1;
      if (f_valid && busy && (n_dropped != 8'hFF)) n_dropped <= n_dropped + 1'b1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_freq_band_selector.sv
// Scoreboard bench for freq_band_selector: directed strobes push expected decisions, a monitor
// compares them whenever busy falls (decision completed).
module tb_freq_band_selector;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] f = '0;
  logic        f_valid = 1'b0;
  logic [7:0]  cap_sel;
  logic [2:0]  band;
  logic        locked, band_change, sig_lost, busy;
`ifdef FREQ_BAND_SELECTOR_STATS_EN
  logic [7:0]  n_changes, n_dropped;
`endif

  freq_band_selector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .f(f), .f_valid(f_valid),
    .cap_sel(cap_sel), .band(band), .locked(locked),
    .band_change(band_change), .sig_lost(sig_lost),
`ifdef FREQ_BAND_SELECTOR_STATS_EN
    .busy(busy), .n_changes(n_changes), .n_dropped(n_dropped)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cap;
    logic [2:0] band;
    logic       locked;
    logic       chg;
    int         blen;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   run = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a decision is presented on the cycle busy drops back to zero
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else if (busy) begin
      run++;
    end else begin
      if (run > 0) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_decision: actual=cap_sel %0h required=no decision at %0t", cap_sel, $time);
        end else begin
          e = q.pop_front();
          chk("cap_sel", int'(cap_sel), int'(e.cap));
          chk("band", int'(band), int'(e.band));
          chk("locked", int'(locked), int'(e.locked));
          chk("band_change", int'(band_change), int'(e.chg));
          chk("busy_len", run, e.blen);
        end
        run = 0;
      end else if (band_change) begin
        chk("spurious_band_change", int'(band_change), 0);
      end
    end
  end

  task automatic strobe(input logic [13:0] fv, input logic [7:0] cap, input logic [2:0] bnd,
                        input logic lk, input logic chg, input int blen, input bit push);
    exp_t x;
    x.cap = cap; x.band = bnd; x.locked = lk; x.chg = chg; x.blen = blen;
    if (push) q.push_back(x);
    @(posedge clk); #1 f = fv; f_valid = 1'b1;
    @(posedge clk); #1 f_valid = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_sel", int'(cap_sel), 0);
    chk("rst_band", int'(band), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_band_change", int'(band_change), 0);
    chk("rst_sig_lost", int'(sig_lost), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Lock band 1
    strobe(14'd800, 8'h00, 3'd0, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd800, 8'h00, 3'd0, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd800, 8'h02, 3'd1, 1'b1, 1'b1, 3, 1'b1);
    // Inside upper hysteresis margin: stays on band 1
    repeat (3) strobe(14'd1005, 8'h02, 3'd1, 1'b1, 1'b0, 4, 1'b1);
    strobe(14'd1020, 8'h02, 3'd1, 1'b1, 1'b0, 4, 1'b1);
    strobe(14'd1020, 8'h02, 3'd1, 1'b1, 1'b0, 4, 1'b1);
    strobe(14'd1020, 8'h04, 3'd2, 1'b1, 1'b1, 4, 1'b1);
    // Top band clamp
    strobe(14'd4000, 8'h04, 3'd2, 1'b1, 1'b0, 9, 1'b1);
    strobe(14'd4000, 8'h04, 3'd2, 1'b1, 1'b0, 9, 1'b1);
    strobe(14'd4000, 8'h80, 3'd7, 1'b1, 1'b1, 9, 1'b1);
    // Below F_MIN: release bank, band held
    strobe(14'd400, 8'h80, 3'd7, 1'b1, 1'b0, 1, 1'b1);
    strobe(14'd400, 8'h80, 3'd7, 1'b1, 1'b0, 1, 1'b1);
    strobe(14'd400, 8'h00, 3'd7, 1'b0, 1'b1, 1, 1'b1);
    // Alternating candidates never confirm
    strobe(14'd800,  8'h00, 3'd7, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd1300, 8'h00, 3'd7, 1'b0, 1'b0, 5, 1'b1);
    strobe(14'd800,  8'h00, 3'd7, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd1300, 8'h00, 3'd7, 1'b0, 1'b0, 5, 1'b1);

    // Strobe while busy is dropped
    e.cap = 8'h00; e.band = 3'd7; e.locked = 1'b0; e.chg = 1'b0; e.blen = 3;
    q.push_back(e);
    @(posedge clk); #1 f = 14'd800; f_valid = 1'b1;
    @(posedge clk); #1 f_valid = 1'b0;
    @(posedge clk); #1 f = 14'd1300; f_valid = 1'b1;
    @(posedge clk); #1 f_valid = 1'b0;
    repeat (20) @(posedge clk);
`ifdef FREQ_BAND_SELECTOR_STATS_EN
    chk("n_dropped", int'(n_dropped), 1);
    chk("n_changes", int'(n_changes), 4);
`endif

    // Lock band 3, then let the signal vanish
    strobe(14'd1300, 8'h00, 3'd7, 1'b0, 1'b0, 5, 1'b1);
    strobe(14'd1300, 8'h00, 3'd7, 1'b0, 1'b0, 5, 1'b1);
    strobe(14'd1300, 8'h08, 3'd3, 1'b1, 1'b1, 5, 1'b1);
    repeat (TO - 50) @(posedge clk);
    #1;
    chk("sig_lost_early", int'(sig_lost), 0);
    chk("locked_early", int'(locked), 1);
    repeat (60) @(posedge clk);
    #1;
    chk("sig_lost_set", int'(sig_lost), 1);
    chk("lost_locked", int'(locked), 0);
    chk("lost_cap_sel", int'(cap_sel), 8'h08);
    chk("lost_band", int'(band), 3);
    strobe(14'd1300, 8'h08, 3'd3, 1'b0, 1'b0, 5, 1'b1);
    chk("sig_lost_clear", int'(sig_lost), 0);
    strobe(14'd1300, 8'h08, 3'd3, 1'b0, 1'b0, 5, 1'b1);
    strobe(14'd1300, 8'h08, 3'd3, 1'b1, 1'b1, 5, 1'b1);

    // Asynchronous reset mid-classification
    @(posedge clk); #1 f = 14'd4000; f_valid = 1'b1;
    @(posedge clk); #1 f_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_cap_sel", int'(cap_sel), 0);
    chk("arst_band", int'(band), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_sig_lost", int'(sig_lost), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    strobe(14'd800, 8'h00, 3'd0, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd800, 8'h00, 3'd0, 1'b0, 1'b0, 3, 1'b1);
    strobe(14'd800, 8'h02, 3'd1, 1'b1, 1'b1, 3, 1'b1);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_band_selector.md
Name: freq_band_selector

Overview:
- Consumes the 14-bit frequency word produced by the upstream frequency counter (units: hundreds of Hz, clock 4 MHz = 40000).
- Classifies each new measurement into one of N_BANDS contiguous frequency bands.
- Applies hysteresis and N-of-N confirmation, then drives a one-hot capacitor-bank select for the antenna matching network.
- Flags loss of signal when measurements stop arriving.

Parameters:
- F_WIDTH, 14, width of frequency input (hundreds of Hz).
- N_BANDS, 8, number of bands; cap_sel width.
- F_MIN, 500, lower edge of band 0 (50 kHz).
- BAND_STEP, 250, band width (25 kHz); must be > 2*HYST.
- HYST, 10, hysteresis margin at band edges.
- N_CONFIRM, 3, consecutive identical classifications required to change output.
- TIMEOUT_CYCLES, 400000, clk cycles without f_valid before sig_lost (100 ms).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- f, in, F_WIDTH, measured frequency from counter.
- f_valid, in, 1, one-cycle strobe, f holds a new measurement.
- cap_sel, out, N_BANDS, one-hot bank select; all-zero = no bank.
- band, out, clog2(N_BANDS), current band index.
- locked, out, 1, a band is confirmed and signal present.
- band_change, out, 1, one-cycle pulse when cap_sel changes.
- sig_lost, out, 1, no measurement within TIMEOUT_CYCLES.
- busy, out, 1, classification in progress.

Behaviour:
- Reset (async, any state): cap_sel=0, band=0, locked=0, band_change=0, sig_lost=0, busy=0; confirm count=0; candidate=NONE; timeout counter=0; FSM=IDLE.
- FSM states: IDLE, CALC, DECIDE.
- IDLE:
  - On f_valid, latch f and go to CALC; busy=1 from the next cycle.
  - If f < F_MIN, candidate=NONE and go directly to DECIDE.
  - Otherwise r=f-F_MIN, k=0.
- CALC, one step per cycle:
  - If r >= BAND_STEP and k < N_BANDS-1, then r -= BAND_STEP and k++.
  - Otherwise go to DECIDE.
  - No divider is used. Top band absorbs all f >= F_MIN+(N_BANDS-1)*BAND_STEP; f is never rejected as too high.
- DECIDE (one cycle), hysteresis applies only while locked:
  - If k==band+1 and r < HYST, k is treated as band.
  - If k==band-1 and r >= BAND_STEP-HYST, k is treated as band.
- Confirmation:
  - If the result equals the stored candidate, confirm count increments, saturating at N_CONFIRM.
  - Otherwise candidate=result and count=1.
- Output update, when count reaches N_CONFIRM:
  - Candidate is a band k different from the current output (or locked=0): band=k, cap_sel=1<<k, locked=1, band_change pulses.
  - Candidate is NONE: cap_sel=0, locked=0, band unchanged; band_change pulses only if cap_sel was nonzero.
- Return to IDLE after DECIDE; busy=0.
- Latency: f_valid to output update is 2+k cycles (max N_BANDS+1).
- f_valid while busy: measurement dropped, no state change. The upstream counter's update period far exceeds N_BANDS+2 cycles.
- Timeout counter:
  - Clears on every f_valid.
  - Saturates at TIMEOUT_CYCLES; on reaching it, sig_lost=1, locked=0, confirm count=0, candidate=NONE.
  - cap_sel is held (last bank stays engaged).
  - Next f_valid clears sig_lost; locked returns only after re-confirmation.
- f=0, the counter's no-signal value, classifies as NONE.

Optional Feature:
- Macro: FREQ_BAND_SELECTOR_STATS_EN.
- Defined: adds outputs n_changes[7:0] and n_dropped[7:0].
  - n_changes: saturating count of band_change pulses.
  - n_dropped: saturating count of f_valid strobes ignored while busy.
  - Both cleared by reset only.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then f=800 strobed 3 times (>=20 cycles apart) -> after the 3rd: band=1, cap_sel=8'b00000010, locked=1, one band_change pulse; no pulse on the 1st/2nd.
- Locked at band 1; f=1005 x3 (k=2, r=5<HYST) -> cap_sel stays 8'b00000010, no band_change. Then f=1020 x3 -> band=2, cap_sel=8'b00000100, one pulse.
- f=4000 x3 -> k clamps to 7, cap_sel=8'b10000000, busy high for exactly 9 cycles per measurement (CALC k steps+1, DECIDE). f=400 x3 -> cap_sel=0, locked=0, band_change pulse.
- Alternating f=800/1300 strobes -> confirm count never reaches 3, outputs unchanged. f_valid asserted 2 cycles after a prior strobe -> dropped (n_dropped=1 when FREQ_BAND_SELECTOR_STATS_EN).
- Locked at band 3; no f_valid for 400000 cycles -> sig_lost=1, locked=0, cap_sel unchanged. Next f_valid clears sig_lost; locked=1 only after 3 confirmations.
- Assert reset during CALC (f=4000 in flight) -> all outputs zero immediately (asynchronous), FSM=IDLE. First strobe after release is classified normally.
